// File: rtl/product_disp_pkg.sv
// Shared types and seven-segment constants for the product display.
// Segment byte layout is {a,b,c,d,e,f,g,dp}, active-high.
package product_disp_pkg;

    typedef enum logic {
        DIG_UNITS = 1'b0,
        DIG_TENS  = 1'b1
    } digit_sel_e;

    localparam logic [7:0] SEG_BLANK = 8'h00;
    localparam logic [7:0] SEG_0     = 8'hFC;
    localparam logic [7:0] SEG_1     = 8'h60;
    localparam logic [7:0] SEG_2     = 8'hDA;
    localparam logic [7:0] SEG_3     = 8'hF2;
    localparam logic [7:0] SEG_4     = 8'h66;
    localparam logic [7:0] SEG_5     = 8'hB6;
    localparam logic [7:0] SEG_6     = 8'hBE;
    localparam logic [7:0] SEG_7     = 8'hE0;
    localparam logic [7:0] SEG_8     = 8'hFE;
    localparam logic [7:0] SEG_9     = 8'hF6;

endpackage

// File: rtl/product_seg_display_seg7_encoder.sv
// Combinational BCD digit to seven-segment code; non-decimal inputs go dark.
module seg7_encoder
    import product_disp_pkg::*;
(
    input  logic [3:0] digit,
    output logic [7:0] seg
);

    // Decode one decimal digit to its segment pattern
    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/product_seg_display.sv
// Captures a 4-bit product and shows it as two time-multiplexed decimal digits
// with leading-zero suppression of the tens digit and a global blank control.
module product_seg_display
    import product_disp_pkg::*;
#(
    parameter int CNT_MAX = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] product_in,
    input  logic       load,
    input  logic       blank,
    output logic [7:0] seg_out,
    output logic [1:0] seg_en
);

    localparam int            CW       = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);

    logic [3:0]    prod_q, prod_d;
    logic [CW-1:0] scan_cnt_q, scan_cnt_d;
    digit_sel_e    digit_sel_q, digit_sel_d;
    logic [7:0]    seg_out_q, seg_out_d;
    logic [1:0]    seg_en_q, seg_en_d;

    logic          terminal_s;
    logic          tens_s;
    logic [3:0]    units_s;
    logic [3:0]    digit_s;
    logic [7:0]    code_s;

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q      <= 4'd0;
            scan_cnt_q  <= '0;
            digit_sel_q <= DIG_UNITS;
            seg_out_q   <= SEG_BLANK;
            seg_en_q    <= 2'b00;
        end else begin
            prod_q      <= prod_d;
            scan_cnt_q  <= scan_cnt_d;
            digit_sel_q <= digit_sel_d;
            seg_out_q   <= seg_out_d;
            seg_en_q    <= seg_en_d;
        end
    end

    // Capture register and refresh divider
    always_comb begin
        prod_d     = prod_q;
        scan_cnt_d = scan_cnt_q;
        terminal_s = (scan_cnt_q == CNT_LAST);
        if (load) begin
            prod_d = product_in;
        end else begin
            prod_d = prod_q;
        end
        if (terminal_s) begin
            scan_cnt_d = '0;
        end else begin
            scan_cnt_d = scan_cnt_q + CW'(1);
        end
    end

    // Digit-select next state
    always_comb begin
        digit_sel_d = DIG_UNITS;
        case (digit_sel_q)
            DIG_UNITS: digit_sel_d = terminal_s ? DIG_TENS  : DIG_UNITS;
            DIG_TENS:  digit_sel_d = terminal_s ? DIG_UNITS : DIG_TENS;
            default:   digit_sel_d = DIG_UNITS;
        endcase
    end

    // Product is at most 15, so tens is a single compare against ten
    always_comb begin
        tens_s  = (prod_q >= 4'd10);
        units_s = prod_q;
        digit_s = prod_q;
        if (tens_s) begin
            units_s = prod_q - 4'd10;
        end else begin
            units_s = prod_q;
        end
        if (digit_sel_q == DIG_TENS) begin
            digit_s = {3'b000, tens_s};
        end else begin
            digit_s = units_s;
        end
    end

    seg7_encoder u_seg7_encoder (
        .digit (digit_s),
        .seg   (code_s)
    );

    // Output decode; blank overrides everything
    always_comb begin
        seg_out_d = SEG_BLANK;
        seg_en_d  = 2'b00;
        if (blank) begin
            seg_out_d = SEG_BLANK;
            seg_en_d  = 2'b00;
        end else begin
            case (digit_sel_q)
                DIG_UNITS: begin
                    seg_out_d = code_s;
                    seg_en_d  = 2'b01;
                end
                DIG_TENS: begin
                    if (tens_s) begin
                        seg_out_d = code_s;
                        seg_en_d  = 2'b10;
                    end else begin
                        seg_out_d = SEG_BLANK;
                        seg_en_d  = 2'b00;
                    end
                end
                default: begin
                    seg_out_d = SEG_BLANK;
                    seg_en_d  = 2'b00;
                end
            endcase
        end
    end

    assign seg_out = seg_out_q;
    assign seg_en  = seg_en_q;

endmodule

// File: tb/tb_product_seg_display.sv
// Randomized and directed checks of product_seg_display against an
// arithmetic model: slot = (edges/CNT_MAX) mod 2, digits = prod/10, prod%10.
module tb_product_seg_display;

    localparam int CNT_MAX = 4;

    logic       clk;
    logic       rst_n;
    logic [3:0] product_in;
    logic       load;
    logic       blank;
    logic [7:0] seg_out;
    logic [1:0] seg_en;

    int n_cmp;
    int n_bad;

    int m_edges;
    int m_prod;
    logic [7:0] seg_tbl [10];

    product_seg_display #(.CNT_MAX(CNT_MAX)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .product_in (product_in),
        .load       (load),
        .blank      (blank),
        .seg_out    (seg_out),
        .seg_en     (seg_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h expected %02h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Called at a negedge: drive inputs, let one rising edge pass, check outputs.
    task automatic cycle(input logic l, input logic [3:0] p, input logic b);
        logic [7:0] e_out;
        logic [1:0] e_en;
        int tens, units, slot;
        load = l; product_in = p; blank = b;
        @(posedge clk);
        slot  = (m_edges / CNT_MAX) % 2;
        tens  = m_prod / 10;
        units = m_prod % 10;
        if (b) begin
            e_out = 8'h00; e_en = 2'b00;
        end else if (slot == 0) begin
            e_out = seg_tbl[units]; e_en = 2'b01;
        end else if (tens != 0) begin
            e_out = seg_tbl[tens]; e_en = 2'b10;
        end else begin
            e_out = 8'h00; e_en = 2'b00;
        end
        if (l) m_prod = int'(p);
        m_edges++;
        @(negedge clk);
        chk("seg_out", seg_out, e_out);
        chk("seg_en", {6'd0, seg_en}, {6'd0, e_en});
    endtask

    task automatic idle_until(input int phase);
        for (int i = 0; i < 2 * CNT_MAX && (m_edges % CNT_MAX) != phase; i++)
            cycle(1'b0, 4'd0, 1'b0);
    endtask

    initial begin
        seg_tbl = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0, 8'hFE, 8'hF6};
        n_cmp = 0; n_bad = 0;
        rst_n = 1'b0; load = 1'b0; product_in = 4'd0; blank = 1'b0;
        m_edges = 0; m_prod = 0;

        #12;
        chk("rst_seg_out", seg_out, 8'h00);
        chk("rst_seg_en", {6'd0, seg_en}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // idle after reset: shows 0 in units slot, tens dark
        for (int i = 0; i < 12; i++) cycle(1'b0, 4'd0, 1'b0);
        // product 9, then 12
        cycle(1'b1, 4'd9, 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b0, 4'd0, 1'b0);
        cycle(1'b1, 4'd12, 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b0, 4'd0, 1'b0);

        // load 6 on a terminal-count edge starting from prod 0
        cycle(1'b1, 4'd0, 1'b0);
        idle_until(CNT_MAX - 1);
        cycle(1'b1, 4'd6, 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b0, 4'd0, 1'b0);

        // blank for 10 cycles with prod 12, load under blank still captures
        cycle(1'b1, 4'd12, 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b0, 4'd0, 1'b1);
        cycle(1'b1, 4'd15, 1'b1);
        for (int i = 0; i < 10; i++) cycle(1'b0, 4'd0, 1'b0);

        // asynchronous reset in the middle of a slot
        cycle(1'b1, 4'd12, 1'b0);
        idle_until(2);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_seg_out", seg_out, 8'h00);
        chk("async_rst_seg_en", {6'd0, seg_en}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        m_edges = 0; m_prod = 0;
        for (int i = 0; i < 10; i++) cycle(1'b0, 4'd0, 1'b0);

        // random traffic
        for (int i = 0; i < 400; i++)
            cycle(1'($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 7) == 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
